// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the reconfigurable FIR: turns a valid/ready coefficient
// stream into single-port SRAM writes. Optional checksum logic under COEFF_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | filter running, multiply/accumulate enabled, waiting for iStart
// ENTER  | one cycle: filter switched to update mode, index cleared
// LOAD   | ready high, waiting for a coefficient handshake
// WRITE  | one cycle: RAM strobes low for the captured coefficient
// FINISH | one cycle: update flag dropped, oDone pulsed
module fir_coeff_loader #(
  parameter int NUM_COEFF = 40,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 16
) (
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
`ifdef COEFF_CHECKSUM_EN
  input  logic [DATA_W-1:0] iChecksum,
  output logic              oChkErr,
`endif
  output logic              oCoeffReady,
  output logic              oCoeffUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWtDtRam,
  output logic              oEnMul,
  output logic              oEnAddAcc,
  output logic              oBusy,
  output logic              oDone
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_COEFF - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTER  = 3'd1,
    LOAD   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
`ifdef COEFF_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state            <= IDLE;
      count            <= '0;
      oCoeffReady      <= 1'b0;
      oCoeffUpdateFlag <= 1'b0;
      oCsnRam          <= 1'b1;
      oWrnRam          <= 1'b1;
      oAddrRam         <= '0;
      oWtDtRam         <= '0;
      oEnMul           <= 1'b0;
      oEnAddAcc        <= 1'b0;
      oBusy            <= 1'b0;
      oDone            <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
      sum              <= '0;
      oChkErr          <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          oEnMul           <= 1'b1;
          oEnAddAcc        <= 1'b1;
          oCoeffUpdateFlag <= 1'b0;
          oCsnRam          <= 1'b1;
          oWrnRam          <= 1'b1;
          oBusy            <= 1'b0;
          oCoeffReady      <= 1'b0;
          // Abort takes priority over a simultaneous start.
          if (iStart && !iAbort) begin
            state            <= ENTER;
            oEnMul           <= 1'b0;
            oEnAddAcc        <= 1'b0;
            oCoeffUpdateFlag <= 1'b1;
            oBusy            <= 1'b1;
            count            <= '0;
`ifdef COEFF_CHECKSUM_EN
            sum              <= '0;
            oChkErr          <= 1'b0;
`endif
          end
        end

        ENTER, LOAD, WRITE: begin
          if (iAbort) begin
            // Partial RAM contents are left as written; the caller restarts.
            state            <= IDLE;
            count            <= '0;
            oCsnRam          <= 1'b1;
            oWrnRam          <= 1'b1;
            oCoeffReady      <= 1'b0;
            oCoeffUpdateFlag <= 1'b0;
            oBusy            <= 1'b0;
            oEnMul           <= 1'b1;
            oEnAddAcc        <= 1'b1;
          end else if (state == ENTER) begin
            state       <= LOAD;
            oCoeffReady <= 1'b1;
          end else if (state == LOAD) begin
            if (iCoeffValid && oCoeffReady) begin
              state       <= WRITE;
              oWtDtRam    <= iCoeffData;
              oAddrRam    <= count[ADDR_W-1:0];
              oCsnRam     <= 1'b0;
              oWrnRam     <= 1'b0;
              oCoeffReady <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
              sum         <= sum + iCoeffData;
`endif
            end
          end else begin
            oCsnRam <= 1'b1;
            oWrnRam <= 1'b1;
            count   <= count + CNT_W'(1);
            if (count == LAST_IDX) begin
              state            <= FINISH;
              oCoeffUpdateFlag <= 1'b0;
              oDone            <= 1'b1;
              oAddrRam         <= '0;
`ifdef COEFF_CHECKSUM_EN
              oChkErr          <= (sum != iChecksum);
`endif
            end else begin
              state       <= LOAD;
              oCoeffReady <= 1'b1;
            end
          end
        end

        FINISH: begin
          state     <= IDLE;
          count     <= '0;
          oBusy     <= 1'b0;
          oEnMul    <= 1'b1;
          oEnAddAcc <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: directed sequence with random data and
// valid gaps, checked against a queue model of the expected RAM write stream.
`timescale 1ns/1ps
module tb_fir_coeff_loader;

  localparam int N = 40;

  logic        iClk12M = 1'b0;
  logic        iRsn = 1'b1;
  logic        iStart = 1'b0;
  logic        iAbort = 1'b0;
  logic        iCoeffValid = 1'b0;
  logic [15:0] iCoeffData = '0;
  logic        oCoeffReady, oCoeffUpdateFlag, oCsnRam, oWrnRam;
  logic [5:0]  oAddrRam;
  logic [15:0] oWtDtRam;
  logic        oEnMul, oEnAddAcc, oBusy, oDone;

  int total = 0;
  int bad = 0;

  always #41 iClk12M = ~iClk12M;

`ifdef COEFF_CHECKSUM_EN
  logic [15:0] iChecksum = '0;
  logic        oChkErr;
`endif

  fir_coeff_loader #(.NUM_COEFF(N), .ADDR_W(6), .DATA_W(16)) u_dut (
    .iClk12M(iClk12M), .iRsn(iRsn), .iStart(iStart), .iAbort(iAbort),
    .iCoeffValid(iCoeffValid), .iCoeffData(iCoeffData),
`ifdef COEFF_CHECKSUM_EN
    .iChecksum(iChecksum), .oChkErr(oChkErr),
`endif
    .oCoeffReady(oCoeffReady), .oCoeffUpdateFlag(oCoeffUpdateFlag),
    .oCsnRam(oCsnRam), .oWrnRam(oWrnRam), .oAddrRam(oAddrRam), .oWtDtRam(oWtDtRam),
    .oEnMul(oEnMul), .oEnAddAcc(oEnAddAcc), .oBusy(oBusy), .oDone(oDone)
  );

`ifdef COEFF_CHECKSUM_EN
  logic        cStart = 1'b0;
  logic        cValid = 1'b0;
  logic [15:0] cData = '0;
  logic [15:0] cChecksum = '0;
  logic        cReady, cFlag, cCsn, cWrn, cEnMul, cEnAcc, cBusy, cDone, cChkErr;
  logic [5:0]  cAddr;
  logic [15:0] cWd;

  fir_coeff_loader #(.NUM_COEFF(2), .ADDR_W(6), .DATA_W(16)) u_chk (
    .iClk12M(iClk12M), .iRsn(iRsn), .iStart(cStart), .iAbort(1'b0),
    .iCoeffValid(cValid), .iCoeffData(cData),
    .iChecksum(cChecksum), .oChkErr(cChkErr),
    .oCoeffReady(cReady), .oCoeffUpdateFlag(cFlag),
    .oCsnRam(cCsn), .oWrnRam(cWrn), .oAddrRam(cAddr), .oWtDtRam(cWd),
    .oEnMul(cEnMul), .oEnAddAcc(cEnAcc), .oBusy(cBusy), .oDone(cDone)
  );
`endif

  // Observed RAM write stream and event counters
  int          cyc = 0;
  int          doneCnt = 0;
  int          readyInWrite = 0;
  logic [5:0]  obsAddr[$];
  logic [15:0] obsData[$];
  int          obsCyc[$];
  logic [15:0] expQ[$];

  always @(negedge iClk12M) begin
    cyc <= cyc + 1;
    if (iRsn && !oCsnRam && !oWrnRam) begin
      obsAddr.push_back(oAddrRam);
      obsData.push_back(oWtDtRam);
      obsCyc.push_back(cyc);
      if (oCoeffReady) readyInWrite <= readyInWrite + 1;
    end
    if (iRsn && oDone) doneCnt <= doneCnt + 1;
  end

  task automatic tick();
    @(posedge iClk12M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearQ();
    obsAddr.delete(); obsData.delete(); obsCyc.delete(); expQ.delete();
  endtask

  // Offer one coefficient, valid on pct% of cycles, until the loader takes it.
  task automatic pushCoeff(input logic [15:0] d, input int pct);
    int  guard = 0;
    bit  sent = 0;
    iCoeffData = d;
    while (!sent && guard < 300) begin
      iCoeffValid = ($urandom_range(99) < pct);
      if (iCoeffValid && oCoeffReady) begin
        sent = 1;
        expQ.push_back(d);
      end
      tick();
      guard++;
    end
    iCoeffValid = 1'b0;
    if (!sent) chk("push_timeout", 32'(sent), 32'd1);
  endtask

  task automatic startUpdate();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic checkStream(input string tag, input int n);
    chk({tag, "_count"}, 32'(obsAddr.size()), 32'(n));
    chk({tag, "_expcount"}, 32'(expQ.size()), 32'(n));
    if (obsAddr.size() == n && expQ.size() == n)
      for (int i = 0; i < n; i++) begin
        chk({tag, "_addr"}, 32'(obsAddr[i]), 32'(i));
        chk({tag, "_data"}, 32'(obsData[i]), 32'(expQ[i]));
      end
  endtask

  task automatic runFull(input string tag, input int pct, input bit randData);
    int guard = 0;
    int doneBase = doneCnt;
    clearQ();
    startUpdate();
    chk({tag, "_enter_flag"}, 32'(oCoeffUpdateFlag), 32'd1);
    chk({tag, "_enter_busy"}, 32'(oBusy), 32'd1);
    chk({tag, "_enter_enmul"}, 32'(oEnMul), 32'd0);
    for (int k = 0; k < N; k++)
      pushCoeff(randData ? 16'($urandom) : 16'(k + 1), pct);
    while (!oDone && guard < 20) begin
      tick();
      guard++;
    end
    chk({tag, "_done"}, 32'(oDone), 32'd1);
    chk({tag, "_finish_flag"}, 32'(oCoeffUpdateFlag), 32'd0);
    chk({tag, "_finish_addr"}, 32'(oAddrRam), 32'd0);
    tick();
    chk({tag, "_idle_enmul"}, 32'(oEnMul), 32'd1);
    chk({tag, "_idle_enacc"}, 32'(oEnAddAcc), 32'd1);
    chk({tag, "_idle_busy"}, 32'(oBusy), 32'd0);
    chk({tag, "_idle_done"}, 32'(oDone), 32'd0);
    checkStream(tag, N);
    chk({tag, "_done_pulses"}, 32'(doneCnt - doneBase), 32'd1);
    chk({tag, "_ready_in_write"}, 32'(readyInWrite), 32'd0);
    if (pct == 100 && obsCyc.size() == N)
      for (int i = 1; i < N; i++)
        chk({tag, "_gap"}, 32'(obsCyc[i] - obsCyc[i-1]), 32'd2);
  endtask

  initial begin
    int doneBase;
    #5 iRsn = 1'b0;
    #5;
    chk("rst_csn", 32'(oCsnRam), 32'd1);
    chk("rst_wrn", 32'(oWrnRam), 32'd1);
    chk("rst_addr", 32'(oAddrRam), 32'd0);
    chk("rst_data", 32'(oWtDtRam), 32'd0);
    chk("rst_flag", 32'(oCoeffUpdateFlag), 32'd0);
    chk("rst_ready", 32'(oCoeffReady), 32'd0);
    chk("rst_enmul", 32'(oEnMul), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    tick(); tick();
    iRsn = 1'b1;
    repeat (5) tick();
    chk("idle_enmul", 32'(oEnMul), 32'd1);
    chk("idle_enacc", 32'(oEnAddAcc), 32'd1);
    chk("idle_csn", 32'(oCsnRam), 32'd1);
    chk("idle_wrn", 32'(oWrnRam), 32'd1);
    chk("idle_flag", 32'(oCoeffUpdateFlag), 32'd0);
    chk("idle_busy", 32'(oBusy), 32'd0);

    runFull("b2b", 100, 1'b0);
    runFull("gaps", 30, 1'b1);

    // Abort after 12 coefficients, then restart from address 0
    clearQ();
    doneBase = doneCnt;
    startUpdate();
    for (int k = 0; k < 12; k++) pushCoeff(16'($urandom), 100);
    tick();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    chk("abort_busy", 32'(oBusy), 32'd0);
    chk("abort_flag", 32'(oCoeffUpdateFlag), 32'd0);
    chk("abort_csn", 32'(oCsnRam), 32'd1);
    chk("abort_ready", 32'(oCoeffReady), 32'd0);
    repeat (3) tick();
    chk("abort_enmul", 32'(oEnMul), 32'd1);
    chk("abort_nodone", 32'(doneCnt - doneBase), 32'd0);
    checkStream("abort12", 12);
    clearQ();
    startUpdate();
    for (int k = 0; k < 3; k++) pushCoeff(16'($urandom), 100);
    tick();
    checkStream("restart", 3);

    // iStart in LOAD is ignored; abort with a handshake writes nothing
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    tick();
    clearQ();
    startUpdate();
    for (int k = 0; k < 2; k++) pushCoeff(16'($urandom), 100);
    tick();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("start_in_load_busy", 32'(oBusy), 32'd1);
    chk("start_in_load_flag", 32'(oCoeffUpdateFlag), 32'd1);
    chk("start_in_load_ready", 32'(oCoeffReady), 32'd1);
    iCoeffValid = 1'b1;
    iCoeffData  = 16'hBEEF;
    iAbort      = 1'b1;
    tick();
    iCoeffValid = 1'b0;
    iAbort      = 1'b0;
    chk("abort_hs_csn", 32'(oCsnRam), 32'd1);
    chk("abort_hs_wrn", 32'(oWrnRam), 32'd1);
    chk("abort_hs_busy", 32'(oBusy), 32'd0);
    tick();
    checkStream("abort_hs", 2);

    // Start and abort together in IDLE: abort wins
    iStart = 1'b1;
    iAbort = 1'b1;
    tick();
    iStart = 1'b0;
    iAbort = 1'b0;
    chk("start_abort_busy", 32'(oBusy), 32'd0);
    chk("start_abort_flag", 32'(oCoeffUpdateFlag), 32'd0);
    tick();
    chk("start_abort_busy2", 32'(oBusy), 32'd0);

    // Reset in the middle of an update
    clearQ();
    startUpdate();
    for (int k = 0; k < 5; k++) pushCoeff(16'($urandom), 100);
    #10 iRsn = 1'b0;
    #2;
    chk("midrst_csn", 32'(oCsnRam), 32'd1);
    chk("midrst_wrn", 32'(oWrnRam), 32'd1);
    chk("midrst_flag", 32'(oCoeffUpdateFlag), 32'd0);
    chk("midrst_busy", 32'(oBusy), 32'd0);
    chk("midrst_enmul", 32'(oEnMul), 32'd0);
    chk("midrst_addr", 32'(oAddrRam), 32'd0);
    tick();
    iRsn = 1'b1;
    tick(); tick();
    chk("postrst_enmul", 32'(oEnMul), 32'd1);
    chk("postrst_busy", 32'(oBusy), 32'd0);
    runFull("post_reset", 100, 1'b1);

`ifdef COEFF_CHECKSUM_EN
    // 0x8000 + 0x8001 wraps to 0x0001
    for (int t = 0; t < 2; t++) begin
      int guard = 0;
      cChecksum = (t == 0) ? 16'h0001 : 16'h0002;
      cStart = 1'b1;
      tick();
      cStart = 1'b0;
      for (int k = 0; k < 2; k++) begin
        bit sent = 0;
        cData = (k == 0) ? 16'h8000 : 16'h8001;
        guard = 0;
        while (!sent && guard < 20) begin
          cValid = 1'b1;
          if (cReady) sent = 1;
          tick();
          guard++;
        end
        cValid = 1'b0;
      end
      guard = 0;
      while (!cDone && guard < 10) begin
        tick();
        guard++;
      end
      chk("chk_done", 32'(cDone), 32'd1);
      chk("chk_err", 32'(cChkErr), (t == 0) ? 32'd0 : 32'd1);
      repeat (2) tick();
      chk("chk_err_hold", 32'(cChkErr), (t == 0) ? 32'd0 : 32'd1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
